// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the instruction-fetch and data
// ports. Each access is bounded by a timeout, and the CPU is given a combinational stall.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  cpu_rst,
  input  logic                  inst_ren,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_ack,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_ack,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  input  logic                  ram_ack,
  output logic                  cpu_stall,
  output logic                  bus_err
);

  // state       | meaning
  // S_IDLE      | no access; arbitrate pending requests
  // S_INST_BUSY | instruction read on the memory, waiting for ram_ack
  // S_DATA_BUSY | data read/write on the memory, waiting for ram_ack
  // S_RESP      | one-cycle ack to the granted side
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_INST_BUSY = 2'd1,
    S_DATA_BUSY = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  state_t                r_state, w_state;
  logic                  r_last_data, w_last_data;
  logic                  r_grant_data, w_grant_data;
  logic                  r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [DATA_WIDTH-1:0] r_inst_rdata, w_inst_rdata;
  logic [DATA_WIDTH-1:0] r_mem_din, w_mem_din;
  logic [15:0]           r_cnt, w_cnt;
  logic                  r_bus_err, w_bus_err;

  logic w_dreq;
  logic w_pick_data;
  logic w_busy;
  logic w_timeout;

  assign w_dreq      = mem_ren | mem_wen;
  // On contention data wins unless it won last time, so neither side can starve.
  assign w_pick_data = w_dreq & ~(inst_ren & r_last_data);
  assign w_busy      = (r_state == S_INST_BUSY) || (r_state == S_DATA_BUSY);
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  always_comb begin
    w_state      = r_state;
    w_last_data  = r_last_data;
    w_grant_data = r_grant_data;
    w_we         = r_we;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_inst_rdata = r_inst_rdata;
    w_mem_din    = r_mem_din;
    w_cnt        = r_cnt;
    w_bus_err    = r_bus_err;

    case (r_state)
      S_IDLE: begin
        if (w_dreq || inst_ren) begin
          w_grant_data = w_pick_data;
          w_last_data  = w_pick_data;
          w_addr       = w_pick_data ? mem_addr : inst_addr;
          w_we         = w_pick_data & mem_wen;
          w_wdata      = mem_dout;
          w_cnt        = 16'd0;
          w_state      = w_pick_data ? S_DATA_BUSY : S_INST_BUSY;
        end
      end
      S_INST_BUSY, S_DATA_BUSY: begin
        if (ram_ack) begin
          if (r_state == S_INST_BUSY) begin
            w_inst_rdata = ram_rdata;
          end else if (!r_we) begin
            w_mem_din = ram_rdata;
          end
          w_state = S_RESP;
        end else if (w_timeout) begin
          // A dead memory reads back all-ones so the core sees an obviously bad value.
          w_bus_err = 1'b1;
          if (r_state == S_INST_BUSY) begin
            w_inst_rdata = '1;
          end else if (!r_we) begin
            w_mem_din = '1;
          end
          w_state = S_RESP;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_RESP: begin
        w_we    = 1'b0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cpu_rst) begin
      r_state      <= S_IDLE;
      r_last_data  <= 1'b0;
      r_grant_data <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst_rdata <= '0;
      r_mem_din    <= '0;
      r_cnt        <= 16'd0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_data  <= w_last_data;
      r_grant_data <= w_grant_data;
      r_we         <= w_we;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_inst_rdata <= w_inst_rdata;
      r_mem_din    <= w_mem_din;
      r_cnt        <= w_cnt;
      r_bus_err    <= w_bus_err;
    end
  end

  assign ram_cs     = w_busy;
  assign ram_we     = r_we;
  assign ram_addr   = r_addr;
  assign ram_wdata  = r_wdata;
  assign inst_rdata = r_inst_rdata;
  assign mem_din    = r_mem_din;
  assign inst_ack   = (r_state == S_RESP) && !r_grant_data;
  assign mem_ack    = (r_state == S_RESP) && r_grant_data;
  assign bus_err    = r_bus_err;
  assign cpu_stall  = (inst_ren & ~inst_ack) | (w_dreq & ~mem_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. A RAM model, a scoreboard of expected memory accesses and a
// scoreboard of expected acks with their data run alongside the directed stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ack;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_ack;
  logic        ram_cs;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        cpu_stall;
  logic        bus_err;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .cpu_rst(cpu_rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .cpu_stall(cpu_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
  } rsp_t;

  acc_t        acc_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem_model [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int ram_wait = 0;
  bit ram_noack = 1'b0;
  int cs_cnt = 0;
  int last_cs_len = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RAM model: acks after ram_wait cycles of ram_cs, checks each new access on its first cycle.
  always @(negedge clk) begin
    acc_t a;
    if (ram_cs) begin
      if (cs_cnt == 0) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected ram access: addr %0h we %b, none expected", ram_addr, ram_we);
        end else begin
          a = acc_q.pop_front();
          chk("ram_addr", ram_addr, a.addr);
          chk("ram_we", ram_we, a.we);
          if (a.we) chk("ram_wdata", ram_wdata, a.wdata);
        end
      end
      ram_ack = !ram_noack && (cs_cnt == ram_wait);
      if (ram_ack) begin
        ram_rdata = mem_model.exists(ram_addr) ? mem_model[ram_addr] : 32'h0;
        if (ram_we) mem_model[ram_addr] = ram_wdata;
      end else begin
        ram_rdata = 32'hBAD0_BAD0;
      end
      cs_cnt++;
    end else begin
      if (cs_cnt != 0) last_cs_len = cs_cnt;
      cs_cnt    = 0;
      ram_ack   = 1'b0;
      ram_rdata = 32'hBAD0_BAD0;
    end
  end

  // Ack monitor: every ack must match the next expected response.
  always @(negedge clk) begin
    rsp_t r;
    if (!cpu_rst && (inst_ack || mem_ack)) begin
      chk("ack exclusive", inst_ack & mem_ack, 0);
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected ack: inst_ack %b mem_ack %b, none expected", inst_ack, mem_ack);
      end else begin
        r = rsp_q.pop_front();
        chk("ack side", mem_ack, r.is_data);
        chk(r.is_data ? "mem_din" : "inst_rdata", r.is_data ? mem_din : inst_rdata, r.data);
      end
    end
  end

  task automatic do_access(input bit is_d, input bit ren, input bit wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int wt, input bit noack, input logic [31:0] exp_data,
                           input int exp_lat, input string name, output bit stall_at_ack);
    acc_t a;
    rsp_t r;
    int   lat;
    bit   seen;
    a.addr = addr; a.we = is_d & wen; a.wdata = wdata;
    acc_q.push_back(a);
    r.is_data = is_d; r.data = exp_data;
    rsp_q.push_back(r);
    ram_wait  = wt;
    ram_noack = noack;
    @(negedge clk);
    if (is_d) begin
      mem_ren = ren; mem_wen = wen; mem_addr = addr; mem_dout = wdata;
    end else begin
      inst_ren = 1'b1; inst_addr = addr;
    end
    lat = 0; seen = 0; stall_at_ack = 1'b1;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (is_d ? mem_ack : inst_ack) begin
        seen = 1;
        stall_at_ack = cpu_stall;
      end
    end
    chk({name, " latency"}, lat, exp_lat);
    inst_ren = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   stall;
    int   n;
    int   acks;
    acc_t a;
    rsp_t r;

    cpu_rst = 1'b1; inst_ren = 1'b0; inst_addr = '0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
    ram_ack = 1'b0; ram_rdata = '0;
    mem_model[32'h0000_0004] = 32'h2002_0001;
    mem_model[32'h0000_0008] = 32'h0000_0013;
    mem_model[32'h0000_0100] = 32'hA5A5_0100;
    mem_model[32'h0000_0200] = 32'h5A5A_0200;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ram_cs", ram_cs, 0);
    chk("rst ram_we", ram_we, 0);
    chk("rst inst_ack", inst_ack, 0);
    chk("rst mem_ack", mem_ack, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst ram_addr", ram_addr, 0);
    chk("rst ram_wdata", ram_wdata, 0);
    chk("rst inst_rdata", inst_rdata, 0);
    chk("rst mem_din", mem_din, 0);
    chk("rst cpu_stall", cpu_stall, 0);
    cpu_rst = 1'b0;

    // Single fetch, zero wait
    do_access(0, 1, 0, 32'h0000_0004, 32'h0, 0, 0, 32'h2002_0001, 2, "fetch0", stall);
    chk("fetch0 cpu_stall at ack", stall, 0);

    // Reset in the middle of an instruction access
    a.addr = 32'h10; a.we = 1'b0; a.wdata = 32'h0;
    acc_q.push_back(a);
    ram_noack = 1'b1;
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = 32'h10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ram_cs && n < 20);
    chk("rst_mid ram_cs up", ram_cs, 1);
    @(negedge clk);
    cpu_rst = 1'b1; inst_ren = 1'b0;
    @(negedge clk);
    chk("rst_mid ram_cs", ram_cs, 0);
    chk("rst_mid inst_ack", inst_ack, 0);
    chk("rst_mid bus_err", bus_err, 0);
    chk("rst_mid inst_rdata", inst_rdata, 0);
    cpu_rst = 1'b0; ram_noack = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid stays idle", ram_cs, 0);

    // Write then read back
    do_access(1, 0, 1, 32'h40, 32'hDEAD_BEEF, 3, 0, 32'h0, 5, "write40", stall);
    do_access(1, 1, 0, 32'h40, 32'h0, 1, 0, 32'hDEAD_BEEF, 3, "read40", stall);

    // Both enables count as a write; mem_din keeps the previous read
    do_access(1, 1, 1, 32'h44, 32'h1234_5678, 0, 0, 32'hDEAD_BEEF, 2, "rw44", stall);
    do_access(1, 1, 0, 32'h44, 32'h0, 0, 0, 32'h1234_5678, 2, "read44", stall);

    // Fetch so the last grant is INST, then hold both requests: D, I, D, I
    do_access(0, 1, 0, 32'h8, 32'h0, 0, 0, 32'h0000_0013, 2, "fetch8", stall);
    ram_wait = 1;
    for (int i = 0; i < 4; i++) begin
      a.we = 1'b0; a.wdata = 32'h0;
      a.addr = (i % 2 == 0) ? 32'h200 : 32'h100;
      acc_q.push_back(a);
      r.is_data = (i % 2 == 0);
      r.data = (i % 2 == 0) ? 32'h5A5A_0200 : 32'hA5A5_0100;
      rsp_q.push_back(r);
    end
    @(negedge clk);
    inst_ren = 1'b1; inst_addr = 32'h100;
    mem_ren = 1'b1; mem_addr = 32'h200;
    acks = 0; n = 0;
    while (acks < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (inst_ack || mem_ack) acks++;
    end
    chk("contention ack count", acks, 4);
    inst_ren = 1'b0; mem_ren = 1'b0;
    repeat (3) @(negedge clk);

    // Timeout on a data read: 8 busy cycles, all-ones data, sticky bus_err
    chk("pre-timeout bus_err", bus_err, 0);
    do_access(1, 1, 0, 32'h300, 32'h0, 0, 1, 32'hFFFF_FFFF, 9, "timeout", stall);
    @(negedge clk);
    chk("timeout ram_cs cycles", last_cs_len, 8);
    chk("timeout bus_err", bus_err, 1);
    do_access(0, 1, 0, 32'h4, 32'h0, 0, 0, 32'h2002_0001, 2, "post-timeout fetch", stall);
    @(negedge clk);
    chk("bus_err sticky", bus_err, 1);

    repeat (4) @(negedge clk);
    chk("ack queue drained", rsp_q.size(), 0);
    chk("access queue drained", acc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the CPU instruction-fetch port and data-access port (inst_ren/inst_addr and mem_ren/mem_wen/mem_addr/mem_dout sides of the pipeline datapath).
- Arbitrates the two requesters, sequences each access with a request/acknowledge handshake, and returns read data.
- Produces a stall indication that the CPU top level gates into cpu_en.
- Bounds every access with a timeout so a dead memory cannot hang the core.

Parameters:
ADDR_WIDTH, 32, width of all addresses
DATA_WIDTH, 32, width of all data buses
TIMEOUT, 255, max BUSY cycles waiting for ram_ack before abort; 0 disables; legal range 0..65535

Ports:
clk  in  1  main clock
cpu_rst  in  1  synchronous active-high reset
inst_ren  in  1  instruction read request, held until inst_ack
inst_addr  in  ADDR_WIDTH  instruction address
inst_rdata  out  DATA_WIDTH  fetched instruction, registered
inst_ack  out  1  one-cycle pulse: inst_rdata valid, request complete
mem_ren  in  1  data read request, held until mem_ack
mem_wen  in  1  data write request, held until mem_ack
mem_addr  in  ADDR_WIDTH  data address
mem_dout  in  DATA_WIDTH  write data from CPU
mem_din  out  DATA_WIDTH  read data to CPU, registered
mem_ack  out  1  one-cycle pulse: data access complete
ram_cs  out  1  memory access strobe
ram_we  out  1  write enable, valid with ram_cs
ram_addr  out  ADDR_WIDTH  latched access address
ram_wdata  out  DATA_WIDTH  latched write data
ram_rdata  in  DATA_WIDTH  read data, valid when ram_ack=1
ram_ack  in  1  memory completion, sampled only while ram_cs=1
cpu_stall  out  1  combinational stall to CPU
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (cpu_rst=1 at a clk edge, overrides everything, including mid-access):
  - state=IDLE; last_grant=INST.
  - ram_cs, ram_we, inst_ack, mem_ack, bus_err = 0.
  - ram_addr, ram_wdata, inst_rdata, mem_din, timeout counter = 0.
  - An access in flight is dropped; no ack is issued for it.
- States: IDLE, INST_BUSY, DATA_BUSY, RESP.
- IDLE, arbitration:
  - dreq = mem_ren|mem_wen; ireq = inst_ren.
  - Only dreq: grant DATA. Only ireq: grant INST. Neither: stay in IDLE.
  - Both: grant DATA unless last_grant=DATA, in which case grant INST (alternating, starvation-free).
  - On grant, latch ram_addr, ram_we=mem_wen (DATA only; 0 for INST) and ram_wdata=mem_dout; set last_grant; clear counter; go to *_BUSY.
- mem_ren=mem_wen=1 simultaneously is treated as a write.
- *_BUSY:
  - ram_cs=1; address, write enable and write data stay stable.
  - ram_ack=1: capture ram_rdata into inst_rdata (INST) or mem_din (DATA read only; writes leave mem_din unchanged). Drop ram_cs, go to RESP.
  - Otherwise increment the counter. If TIMEOUT≠0 and counter reaches TIMEOUT-1 with no ack: set bus_err, load all-ones (32'hFFFF_FFFF) into the granted side's read register (reads only), drop ram_cs, go to RESP.
- RESP:
  - Pulse inst_ack or mem_ack (granted side) for exactly one cycle; next state IDLE.
  - Result: one idle bubble between accesses; a held request is re-arbitrated in IDLE.
- Latency: request visible in IDLE at cycle t → ram_cs at t+1 → ack at t+2+N, where N = ram_ack wait cycles (N=0 when ram_ack is high on the first BUSY cycle).
- Requesters must not change address or data while the request is pending. The arbiter uses only latched values after the grant.
- cpu_stall = (inst_ren & ~inst_ack) | ((mem_ren|mem_wen) & ~mem_ack).
- bus_err clears only on reset.
- inst_rdata and mem_din hold their value until the next completion on the same side.

Test Plan:
- Reset mid-access: inst fetch addr 0x10, reset asserted in INST_BUSY → next cycle ram_cs=0, state IDLE, inst_ack never pulses, bus_err=0.
- Single fetch, zero wait: inst_ren=1, addr 0x0000_0004, ram_ack on first BUSY cycle with 0x2002_0001 → inst_ack at t+2, inst_rdata=0x2002_0001, cpu_stall low that cycle.
- Write then read: mem_wen addr 0x40 data 0xDEAD_BEEF (3 wait cycles) → ram_we=1, ram_wdata=0xDEAD_BEEF, mem_ack at t+5. Then mem_ren 0x40 → mem_din=0xDEAD_BEEF.
- Contention: inst_ren and mem_ren both held continuously → grant order DATA, INST, DATA, INST; each requester acked every second access.
- Timeout: TIMEOUT=8, ram_ack never asserted → ram_cs high 8 cycles, then mem_ack pulse, mem_din=0xFFFF_FFFF, bus_err=1 and still 1 after a later successful access.
- Both enables: mem_ren=mem_wen=1 → ram_we=1 (write), mem_din unchanged after mem_ack.
